ahb_gpio_irq: RTL and testbench

Parametrised AHB-Lite GPIO peripheral: next-generation GPIO slave with configurable pin count, per-pin direction, input synchronisation, parity generation/checking and edge-triggered interrupts. Sits on the AHB-Lite bus as a zero-wait-state slave; drives/samples a GPIO_W-bit pin bank plus one parity bit.

---
 rtl/ahb_gpio_pkg.sv | 29 ++
 rtl/ahb_gpio_irq_if.sv | 23 ++
 rtl/gpio_sync.sv | 28 ++
 rtl/ahb_gpio_irq.sv | 163 ++++++++++++++++
 tb/tb_ahb_gpio_irq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO block: register offsets, HTRANS codes, reset values.
// Pure declarations, no timing.
// No flow control involved.
package ahb_gpio_pkg;

  // Word offsets (HADDR[4:2]) of the implemented registers
  localparam logic [2:0] OFF_DATA       = 3'd0;
  localparam logic [2:0] OFF_DIR        = 3'd1;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd2;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd3;
  localparam logic [2:0] OFF_EDGE_POL   = 3'd4;

  // AHB-Lite transfer types
  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  // Every register in the block clears to zero
  localparam logic [31:0] REG_RST = 32'h0;

  // A transfer carries an address phase only for NONSEQ and SEQ
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_gpio_irq_if.sv
// AHB-Lite slave-side bus bundle for the GPIO block.
// Wires only, no timing.
// HREADYOUT is returned by the slave; the master/interconnect supplies HREADY.
interface ahb_gpio_irq_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous GPIO pins.
// Latency: STAGES clock edges from pin to synced.
// No backpressure; samples every cycle.
module gpio_sync #(
  parameter int WIDTH  = 17,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the pin sample through the flop chain; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= pins;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign synced = stage[STAGES-1];

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave with per-pin direction, edge interrupts and optional parity (GPIO_IRQ_PARITY_EN).
// Latency: zero-wait reads/writes; GPIOOUT one cycle after write; inputs SYNC_STAGES(+1 for IRQ/parity) edges.
// Never stalls: HREADYOUT is tied high and no error responses are generated.
module ahb_gpio_irq
  import ahb_gpio_pkg::*;
#(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  ahb_gpio_irq_if.slave     bus,
  input  logic [GPIO_W:0]   GPIOIN,
  output logic [GPIO_W:0]   GPIOOUT,
  input  logic              PARITYSEL,
  output logic              PARITYERR,
  output logic              IRQ
);

  logic              accept;
  logic              dp_vld;
  logic              dp_write;
  logic [2:0]        dp_off;
  logic              wr_en;
  logic [GPIO_W-1:0] wdata;

  logic [GPIO_W-1:0] out_data;
  logic [GPIO_W-1:0] dir;
  logic [GPIO_W-1:0] irq_en;
  logic [GPIO_W-1:0] irq_status;
  logic [GPIO_W-1:0] edge_pol;

  logic [GPIO_W:0]   sync_src;
  logic [GPIO_W:0]   sync_in;
  logic [GPIO_W-1:0] sync_prev;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] fall;
  logic [GPIO_W-1:0] edge_hit;
  logic [GPIO_W-1:0] w1c;

  logic [GPIO_W-1:0] pins_out;
  logic              par_out;
  logic              parity_err;
  logic [GPIO_W-1:0] rd_val;
  logic              unused_bits;

  assign accept = bus.HSEL & bus.HREADY & htrans_active(bus.HTRANS);
  assign wr_en  = dp_vld & dp_write & bus.HREADY;
  assign wdata  = bus.HWDATA[GPIO_W-1:0];

  // Capture the accepted address phase; reset abandons any pending data phase
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= 3'd0;
    end else if (bus.HREADY) begin
      dp_vld   <= accept;
      dp_write <= bus.HWRITE;
      dp_off   <= bus.HADDR[4:2];
    end
  end

  // Plain read/write configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= REG_RST[GPIO_W-1:0];
      dir      <= REG_RST[GPIO_W-1:0];
      irq_en   <= REG_RST[GPIO_W-1:0];
      edge_pol <= REG_RST[GPIO_W-1:0];
    end else if (wr_en) begin
      case (dp_off)
        OFF_DATA:     out_data <= wdata;
        OFF_DIR:      dir      <= wdata;
        OFF_IRQ_EN:   irq_en   <= wdata;
        OFF_EDGE_POL: edge_pol <= wdata;
        default:      ;
      endcase
    end
  end

`ifdef GPIO_IRQ_PARITY_EN
  assign sync_src = GPIOIN;
`else
  // Received parity pin is not used; feed a constant so its flops trim away
  assign sync_src = {1'b0, GPIOIN[GPIO_W-1:0]};
`endif

  gpio_sync #(
    .WIDTH  (GPIO_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pins   (sync_src),
    .synced (sync_in)
  );

  // One extra flop of history on the synced data bits for edge detection
  always_ff @(posedge clk) begin
    if (rst) sync_prev <= '0;
    else     sync_prev <= sync_in[GPIO_W-1:0];
  end

  assign rise     = sync_in[GPIO_W-1:0] & ~sync_prev;
  assign fall     = ~sync_in[GPIO_W-1:0] & sync_prev;
  assign edge_hit = ((rise & ~edge_pol) | (fall & edge_pol)) & ~dir;
  assign w1c      = (wr_en && (dp_off == OFF_IRQ_STATUS)) ? wdata : '0;

  // Sticky status: W1C clears, but a new edge in the same cycle wins
  always_ff @(posedge clk) begin
    if (rst) irq_status <= REG_RST[GPIO_W-1:0];
    else     irq_status <= (irq_status & ~w1c) | edge_hit;
  end

  // Output pins only drive bits configured as outputs
  always_ff @(posedge clk) begin
    if (rst) pins_out <= '0;
    else     pins_out <= out_data & dir;
  end

`ifdef GPIO_IRQ_PARITY_EN
  // Generated output parity and received-parity check, both registered
  always_ff @(posedge clk) begin
    if (rst) begin
      par_out    <= PARITYSEL;
      parity_err <= 1'b0;
    end else begin
      par_out    <= (^out_data) ^ PARITYSEL;
      parity_err <= (^sync_in) ^ PARITYSEL;
    end
  end
`else
  assign par_out    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Read mux from the latched offset; idle and write phases return zero
  always_comb begin
    rd_val = '0;
    if (dp_vld && !dp_write) begin
      case (dp_off)
        OFF_DATA:       rd_val = sync_in[GPIO_W-1:0];
        OFF_DIR:        rd_val = dir;
        OFF_IRQ_EN:     rd_val = irq_en;
        OFF_IRQ_STATUS: rd_val = irq_status;
        OFF_EDGE_POL:   rd_val = edge_pol;
        default:        rd_val = '0;
      endcase
    end
  end

  assign bus.HRDATA    = {{(32-GPIO_W){1'b0}}, rd_val};
  assign bus.HREADYOUT = 1'b1;
  assign GPIOOUT       = {par_out, pins_out};
  assign PARITYERR     = parity_err;
  assign IRQ           = |(irq_status & irq_en);

  // Address/data bits outside the decoded range are intentionally ignored
  assign unused_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:GPIO_W],
                         GPIOIN[GPIO_W], sync_in[GPIO_W]};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Randomised scoreboard bench for ahb_gpio_irq against a spec-level reference model.
// Driver updates the model at each clock edge and queues expectations; a monitor pops and compares on the falling edge.
// Works with and without GPIO_IRQ_PARITY_EN.
module tb_ahb_gpio_irq;
  import ahb_gpio_pkg::*;

  localparam int W = 16;
  localparam int S = 2;
`ifdef GPIO_IRQ_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W:0] gout;
    logic       irq;
    logic       perr;
  } pin_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b1;
  logic [W:0] gin = '0;
  logic [W:0] gout;
  logic       perr;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  pin_t        pin_q[$];
  logic [31:0] rd_q[$];

  // Reference model state (architectural view)
  logic [W-1:0] m_out, m_dir, m_ien, m_ists, m_pol;
  logic [W:0]   m_gout;
  logic         m_perr;
  logic [W:0]   h [0:S];      // h[k] = GPIOIN sampled k+1 edges before the next edge
  logic         m_dpv, m_dpw;
  logic [2:0]   m_off;
  logic [31:0]  pend_wd = 32'h0;

  ahb_gpio_irq_if bus();

  ahb_gpio_irq #(.GPIO_W(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .GPIOIN    (gin),
    .GPIOOUT   (gout),
    .PARITYSEL (psel),
    .PARITYERR (perr),
    .IRQ       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply the rules for one rising edge using the inputs present just before it
  task automatic model_edge();
    logic [W:0]   now_s, was_s;
    logic [W-1:0] hits, wd;
    logic [31:0]  rv;
    if (rst) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_ists = '0; m_pol = '0;
      m_gout = {(PAR_EN ? psel : 1'b0), {W{1'b0}}};
      m_perr = 1'b0;
      for (int k = 0; k <= S; k++) h[k] = '0;
      m_dpv = 1'b0; m_dpw = 1'b0; m_off = 3'd0;
      rd_q.push_back(32'h0);
    end else begin
      now_s = h[S-1];
      was_s = h[S];
      hits  = '0;
      for (int i = 0; i < W; i++) begin
        if (!m_dir[i]) begin
          if (!m_pol[i] && !was_s[i] && now_s[i]) hits[i] = 1'b1;
          if (m_pol[i] && was_s[i] && !now_s[i])  hits[i] = 1'b1;
        end
      end
      m_perr = PAR_EN ? ((^now_s) ^ psel) : 1'b0;
      m_gout = {(PAR_EN ? ((^m_out) ^ psel) : 1'b0), m_out & m_dir};
      wd = bus.HWDATA[W-1:0];
      if (m_dpv && m_dpw) begin
        case (m_off)
          3'd0: m_out = wd;
          3'd1: m_dir = wd;
          3'd2: m_ien = wd;
          3'd3: m_ists = m_ists & ~wd;
          3'd4: m_pol = wd;
          default: ;
        endcase
      end
      m_ists = m_ists | hits;
      m_dpv = bus.HSEL && bus.HREADY && bus.HTRANS[1];
      m_dpw = bus.HWRITE;
      m_off = bus.HADDR[4:2];
      for (int k = S; k > 0; k--) h[k] = h[k-1];
      h[0] = gin;
      if (m_dpv && !m_dpw) begin
        case (m_off)
          3'd0:    rv = 32'(h[S-1][W-1:0]);
          3'd1:    rv = 32'(m_dir);
          3'd2:    rv = 32'(m_ien);
          3'd3:    rv = 32'(m_ists);
          3'd4:    rv = 32'(m_pol);
          default: rv = 32'h0;
        endcase
        rd_q.push_back(rv);
      end
    end
    pin_q.push_back('{m_gout, |(m_ists & m_ien), m_perr});
  endtask

  function automatic logic [31:0] mk_addr(input int off);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = off[2:0];
    return a;
  endfunction

  // One bus cycle: drive address phase plus data for the previous one, then step the model
  task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [31:0] d);
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HWDATA = pend_wd;
    pend_wd    = w ? d : $urandom;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    step(1'b1, HT_NONSEQ, mk_addr(off), 1'b1, d);
  endtask

  task automatic rd(input int off);
    step(1'b1, HT_NONSEQ, mk_addr(off), 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, HT_IDLE, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compare pins every cycle, read data whenever a read data phase (or reset) is presented
  initial begin : monitor
    logic was_rst, was_rd;
    pin_t e;
    logic [31:0] er;
    forever begin
      @(posedge clk);
      was_rst = rst;
      was_rd  = bus.HSEL && bus.HREADY && bus.HTRANS[1] && !bus.HWRITE;
      @(negedge clk);
      if (pin_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pin_queue empty got=0 required=1 entries");
      end else begin
        e = pin_q.pop_front();
        chk("gpioout", 32'(gout), 32'(e.gout));
        chk("irq", 32'(irq), 32'(e.irq));
        chk("parityerr", 32'(perr), 32'(e.perr));
        chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
      end
      if (was_rst || was_rd) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL read_queue empty got=0 required=1 entries");
        end else begin
          er = rd_q.pop_front();
          chk("hrdata", bus.HRDATA, er);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : driver
    bus.HREADY = 1'b1;
    bus.HSEL = 1'b0; bus.HTRANS = HT_IDLE; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HWDATA = '0;

    // Reset held three cycles with odd parity selected
    rst = 1'b1; psel = 1'b1; gin = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Output path and generated parity
    psel = 1'b0;
    wr(1, 32'h0000_FFFF);
    wr(0, 32'h0000_0003);
    idle(2);
    wr(0, 32'h0000_0001);
    idle(2);

    // Input path readback, then partial direction masking
    wr(1, 32'h0);
    gin = 17'h0A5A5;
    idle(2);
    rd(0);
    idle(1);
    wr(1, 32'h0000_00FF);
    wr(0, 32'hFFFF_FFFF);
    idle(2);

    // Rising-edge interrupt, W1C, falling edge ignored
    wr(3, 32'hFFFF);
    wr(2, 32'h0001);
    wr(4, 32'h0000);
    wr(1, 32'h0000);
    gin = '0;
    idle(4);
    wr(3, 32'hFFFF);
    idle(1);
    gin = 17'h00001;
    idle(4);
    rd(3);
    wr(3, 32'h0001);
    idle(1);
    gin = '0;
    idle(4);
    rd(3);

    // W1C landing around a new edge on the same bit; dly=1 collides exactly
    for (int dly = 0; dly < 4; dly++) begin
      gin = '0;
      idle(4);
      wr(3, 32'hFFFF);
      idle(1);
      gin = 17'h00001;
      idle(dly);
      wr(3, 32'h0001);
      rd(3);
      idle(1);
    end

    // Falling-edge polarity on a different bit
    wr(4, 32'h0004);
    wr(2, 32'h0004);
    gin = 17'h00004;
    idle(4);
    gin = '0;
    idle(4);
    rd(3);

    // Received parity check
    psel = 1'b0;
    gin = 17'h10000;
    idle(4);
    gin = 17'h10001;
    idle(4);

    // Randomised traffic, including the unused offsets, stalls-free idle/busy and sporadic reset
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) gin = gin ^ ((W+1)'(1) << $urandom_range(0, W));
      if ($urandom_range(0, 40) == 0) gin = (W+1)'($urandom);
      if ($urandom_range(0, 49) == 0) psel = ~psel;
      rst = ($urandom_range(0, 299) == 0);
      if (r < 35)      wr($urandom_range(0, 7), $urandom);
      else if (r < 70) rd($urandom_range(0, 7));
      else if (r < 85) step(1'b1, 2'($urandom_range(0, 1)), mk_addr($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)), $urandom);
      else             step(1'b0, HT_NONSEQ, mk_addr($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)), $urandom);
    end

    rst = 1'b0;
    idle(3);
    @(negedge clk);
    #1;
    n_chk++;
    if (pin_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d/%0d required=0/0", pin_q.size(), rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
